// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, word-wide memory between instruction fetch and load/store.
// Data wins by default; a saturating streak counter bounds how long a waiting fetch can starve.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

  logic [3:0] streak_q, streak_d;
  logic       fetch_rd_q, fetch_rd_d;
  logic       data_rd_q, data_rd_d;
  logic       fetch_win, data_win;

  // Memory is word addressed, so the byte offsets never reach it.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  // Grants are suppressed while reset is held so nothing touches memory.
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (reset) begin
      if (d_req && !(if_req && streak_q >= STREAK_LIM)) begin
        data_win = 1'b1;
      end else if (if_req) begin
        fetch_win = 1'b1;
      end
    end
  end

  always_comb begin
    streak_d   = streak_q;
    fetch_rd_d = fetch_win;
    data_rd_d  = data_win && !d_we;
    if (!if_req || fetch_win) begin
      streak_d = '0;
    end else if (data_win && streak_q < STREAK_LIM) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q   <= '0;
      fetch_rd_q <= 1'b0;
      data_rd_q  <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      fetch_rd_q <= fetch_rd_d;
      data_rd_q  <= data_rd_d;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_win) begin
      mem_en   = 1'b1;
      mem_be   = 4'hF;
      mem_addr = if_addr[ADDR_W-1:2];
    end else if (data_win) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr[ADDR_W-1:2];
      mem_wdata = d_wdata;
    end
  end

  assign if_gnt    = fetch_win;
  assign d_gnt     = data_win;
  assign if_rvalid = fetch_rd_q;
  assign d_rvalid  = data_rd_q;
  assign if_rdata  = fetch_rd_q ? mem_rdata : 32'h0;
  assign d_rdata   = data_rd_q  ? mem_rdata : 32'h0;

endmodule
